// File: rtl/jpu_pkg.sv
// Shared opcodes, instruction field positions and FSM state type for the JPU decode stage.
package jpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_MOV  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int unsigned OP_LSB  = 12;
    localparam int unsigned RD_LSB  = 9;
    localparam int unsigned RA_LSB  = 6;
    localparam int unsigned RB_LSB  = 3;
    localparam int unsigned IR_LSB  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WRITE,
        ST_HALT
    } state_e;

    function automatic logic is_reg_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_MOV) && (op != OP_LDI);
    endfunction

    function automatic logic is_illegal_op(input logic [3:0] op);
        return (op > OP_MOV) && (op != OP_HALT);
    endfunction

endpackage

// File: rtl/jpu_alu.sv
// Combinational ALU: two-operand logic/arithmetic on register-file operands, modulo 2^DATA_W.
module jpu_alu
    import jpu_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_MOV:  y = a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/jpu_decode_ctrl.sv
// Non-pipelined decode/sequencing stage driving the JPU 8x16 register file.
// One instruction in flight; register-file strobes are Moore outputs of state and IR.
module jpu_decode_ctrl
    import jpu_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 3,
    parameter bit          LDI_SIGNEXT = 1'b0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              instr_ready,
    output logic              rf_enable,
    output logic              rf_enable_read,
    output logic              rf_enable_write,
    output logic [ADDR_W-1:0] rf_addrA,
    output logic [ADDR_W-1:0] rf_addrB,
    output logic [DATA_W-1:0] rf_data_in,
    input  logic [DATA_W-1:0] rf_dataA,
    input  logic [DATA_W-1:0] rf_dataB,
    output logic              retired,
    output logic              illegal,
    output logic              halted
);

    state_e             state_q, state_d;
    logic [15:IR_LSB]   ir_q, ir_d;
    logic [DATA_W-1:0]  wb_q, wb_d;
    logic               retired_q, retired_d;
    logic               illegal_q, illegal_d;
    logic [DATA_W-1:0]  alu_y;
    logic [3:0]         acc_op;

    jpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op (ir_q[OP_LSB +: 4]),
        .a  (rf_dataA),
        .b  (rf_dataB),
        .y  (alu_y)
    );

    always_comb begin
        state_d         = state_q;
        ir_d            = ir_q;
        wb_d            = wb_q;
        retired_d       = 1'b0;
        illegal_d       = 1'b0;
        acc_op          = instr[OP_LSB +: 4];
        instr_ready     = 1'b0;
        halted          = 1'b0;
        rf_enable       = 1'b0;
        rf_enable_read  = 1'b0;
        rf_enable_write = 1'b0;
        rf_addrA        = '0;
        rf_addrB        = '0;
        rf_data_in      = '0;

        case (state_q)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    ir_d = instr[15:IR_LSB];
                    if (is_reg_op(acc_op)) begin
                        state_d = ST_READ;
                    end else if (acc_op == OP_LDI) begin
                        state_d = ST_WRITE;
                        wb_d    = LDI_SIGNEXT ? {{(DATA_W-8){instr[7]}}, instr[7:0]}
                                              : {{(DATA_W-8){1'b0}}, instr[7:0]};
                    end else if (acc_op == OP_HALT) begin
                        state_d = ST_HALT;
                    end else begin
                        // NOP and illegal opcodes retire straight from IDLE
                        retired_d = 1'b1;
                        illegal_d = is_illegal_op(acc_op);
                    end
                end
            end
            ST_READ: begin
                rf_enable      = 1'b1;
                rf_enable_read = 1'b1;
                rf_addrA       = ir_q[RA_LSB +: ADDR_W];
                rf_addrB       = ir_q[RB_LSB +: ADDR_W];
                state_d        = ST_EXEC;
            end
            ST_EXEC: begin
                wb_d    = alu_y;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                rf_enable       = 1'b1;
                rf_enable_write = 1'b1;
                rf_addrA        = ir_q[RD_LSB +: ADDR_W];
                rf_data_in      = wb_q;
                retired_d       = 1'b1;
                state_d         = ST_IDLE;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            ir_q      <= '0;
            wb_q      <= '0;
            retired_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            wb_q      <= wb_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    assign retired = retired_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_jpu_decode_ctrl.sv
// Scoreboard bench for jpu_decode_ctrl with a behavioural register file and ISA-level reference model.
module tb_jpu_decode_ctrl;

    localparam bit SIGNEXT = 1'b1;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_ready;
    logic        rf_enable, rf_enable_read, rf_enable_write;
    logic [2:0]  rf_addrA, rf_addrB;
    logic [15:0] rf_data_in;
    logic [15:0] rf_dataA = '0;
    logic [15:0] rf_dataB = '0;
    logic        retired, illegal, halted;

    logic [15:0] regs   [8] = '{default: '0};
    logic [15:0] ref_rf [8] = '{default: '0};

    typedef struct { int unsigned cyc; logic [2:0] addr; logic [15:0] data; } wr_t;
    typedef struct { int unsigned cyc; bit ill; } rt_t;
    wr_t wq[$];
    rt_t rq[$];

    int unsigned cyc = 0;
    int checks = 0;
    int failures = 0;

    jpu_decode_ctrl #(
        .DATA_W      (16),
        .ADDR_W      (3),
        .LDI_SIGNEXT (SIGNEXT)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_ready     (instr_ready),
        .rf_enable       (rf_enable),
        .rf_enable_read  (rf_enable_read),
        .rf_enable_write (rf_enable_write),
        .rf_addrA        (rf_addrA),
        .rf_addrB        (rf_addrB),
        .rf_data_in      (rf_data_in),
        .rf_dataA        (rf_dataA),
        .rf_dataB        (rf_dataB),
        .retired         (retired),
        .illegal         (illegal),
        .halted          (halted)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Register file model following the file's enable/strobe contract
    always @(posedge clock) begin
        if (rf_enable) begin
            if (rf_enable_read) begin
                rf_dataA <= regs[rf_addrA];
                rf_dataB <= regs[rf_addrB];
            end else if (rf_enable_write) begin
                regs[rf_addrA] <= rf_data_in;
            end else begin
                rf_dataA <= '0;
                rf_dataB <= '0;
            end
        end
    end

    // Monitor: pops expected writes/retirements as the DUT presents them
    always @(negedge clock) begin
        wr_t w;
        rt_t r;
        if (rf_enable) begin
            checks++;
            if (rf_enable_read == rf_enable_write) begin
                failures++;
                $display("FAIL rf_strobes got read=%0b write=%0b exp exactly one", rf_enable_read, rf_enable_write);
            end
        end
        if (rf_enable && rf_enable_write) begin
            checks++;
            if (wq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got addr=%0d data=%04h cyc=%0d exp none", rf_addrA, rf_data_in, cyc);
            end else begin
                w = wq.pop_front();
                if (rf_addrA !== w.addr || rf_data_in !== w.data || cyc != w.cyc) begin
                    failures++;
                    $display("FAIL write got addr=%0d data=%04h cyc=%0d exp addr=%0d data=%04h cyc=%0d",
                             rf_addrA, rf_data_in, cyc, w.addr, w.data, w.cyc);
                end
            end
        end
        if (retired) begin
            checks++;
            if (rq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_retire got illegal=%0b cyc=%0d exp none", illegal, cyc);
            end else begin
                r = rq.pop_front();
                if (illegal !== r.ill || cyc != r.cyc) begin
                    failures++;
                    $display("FAIL retire got illegal=%0b cyc=%0d exp illegal=%0b cyc=%0d", illegal, cyc, r.ill, r.cyc);
                end
            end
        end else if (illegal) begin
            checks++;
            failures++;
            $display("FAIL illegal_no_retire got illegal=1 retired=0 exp retired=1");
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // ISA-level model: update architectural state and schedule observable events
    function automatic void model(input logic [15:0] ins, input int unsigned c);
        logic [3:0]  op  = ins[15:12];
        logic [2:0]  rd  = ins[11:9];
        logic [15:0] a   = ref_rf[ins[8:6]];
        logic [15:0] b   = ref_rf[ins[5:3]];
        logic [15:0] imm = {8'h00, ins[7:0]};
        logic [15:0] res = '0;
        case (op)
            4'h1: res = a + b;
            4'h2: res = a - b;
            4'h3: res = a & b;
            4'h4: res = a | b;
            4'h5: res = a ^ b;
            4'h7: res = a;
            4'h6: res = (SIGNEXT && imm >= 16'd128) ? imm + 16'hFF00 : imm;
            default: res = '0;
        endcase
        if (op == 4'h6) begin
            ref_rf[rd] = res;
            wq.push_back('{c, rd, res});
            rq.push_back('{c + 1, 1'b0});
        end else if (op >= 4'h1 && op <= 4'h7) begin
            ref_rf[rd] = res;
            wq.push_back('{c + 2, rd, res});
            rq.push_back('{c + 3, 1'b0});
        end else if (op == 4'h0) begin
            rq.push_back('{c, 1'b0});
        end else if (op != 4'hF) begin
            rq.push_back('{c, 1'b1});
        end
    endfunction

    task automatic issue(input logic [15:0] ins, input bit track);
        int unsigned waited = 0;
        @(negedge clock);
        while (!instr_ready && waited < 20) begin
            instr_valid = 1'($urandom_range(0, 1));
            instr       = 16'($urandom);
            waited++;
            @(negedge clock);
        end
        if (!instr_ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout got ready=0 exp ready=1 within 20 cycles");
            instr_valid = 1'b0;
            return;
        end
        instr_valid = 1'b1;
        instr       = ins;
        @(posedge clock);
        #1;
        instr_valid = 1'b0;
        instr       = 16'($urandom);
        if (track) model(ins, cyc);
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((wq.size() != 0 || rq.size() != 0) && n < 30) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        checks++;
        if (wq.size() != 0 || rq.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout got pending_writes=%0d pending_retires=%0d exp 0", wq.size(), rq.size());
            wq.delete();
            rq.delete();
        end
    endtask

    initial begin
        logic [3:0] op;

        repeat (3) @(negedge clock);
        chk("reset_ready", {31'd0, instr_ready}, 32'd1);
        chk("reset_rf_ctl", {29'd0, rf_enable, rf_enable_read, rf_enable_write}, 32'd0);
        chk("reset_rf_addr_data", {10'd0, rf_addrA, rf_addrB, rf_data_in}, 32'd0);
        chk("reset_flags", {29'd0, retired, illegal, halted}, 32'd0);
        reset_n = 1'b1;

        issue(16'h6212, 1'b1);
        drain();
        chk("ldi_r1_0x12", {16'd0, regs[1]}, 32'h0012);

        issue(16'h6205, 1'b1);
        issue(16'h6403, 1'b1);
        issue(16'h2650, 1'b1);
        drain();
        chk("sub_r3", {16'd0, regs[3]}, 32'h0002);

        issue(16'h2888, 1'b1);
        issue(16'h6A80, 1'b1);
        drain();
        chk("sub_wrap_r4", {16'd0, regs[4]}, 32'hFFFE);
        chk("ldi_sext_r5", {16'd0, regs[5]}, 32'hFF80);

        issue(16'h9000, 1'b1);
        @(negedge clock);
        chk("illegal_ready_next", {31'd0, instr_ready}, 32'd1);
        chk("illegal_no_rf", {31'd0, rf_enable}, 32'd0);
        drain();

        issue(16'h1C50, 1'b0);
        reset_n = 1'b0;
        repeat (2) begin
            instr_valid = 1'($urandom_range(0, 1));
            instr       = 16'($urandom);
            @(negedge clock);
            chk("reset_mid_no_write", {31'd0, rf_enable_write}, 32'd0);
        end
        instr_valid = 1'b0;
        reset_n = 1'b1;
        drain();
        chk("r6_unchanged", {16'd0, regs[6]}, {16'd0, ref_rf[6]});

        for (int i = 0; i < 200; i++) begin
            op = 4'($urandom_range(0, 14));
            issue({op, 12'($urandom)}, 1'b1);
        end
        drain();
        for (int i = 0; i < 8; i++) chk($sformatf("rf_r%0d", i), {16'd0, regs[i]}, {16'd0, ref_rf[i]});

        issue(16'hF000, 1'b0);
        for (int i = 0; i < 10; i++) begin
            instr_valid = 1'b1;
            instr       = 16'($urandom);
            @(negedge clock);
            chk("halt_ready", {31'd0, instr_ready}, 32'd0);
            chk("halt_halted", {31'd0, halted}, 32'd1);
        end
        instr_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("halt_reset_halted", {31'd0, halted}, 32'd0);
        chk("halt_reset_ready", {31'd0, instr_ready}, 32'd1);
        issue(16'h6E7F, 1'b1);
        drain();
        chk("post_halt_ldi_r7", {16'd0, regs[7]}, 32'h007F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
